// File: rtl/scoreboard_counter.sv
// scoreboard_counter: multi-channel bounded up/down score counter.
// Each channel synchronises its asynchronous up/down button levels, turns
// every rising edge into a single request pulse and keeps a count in
// [0, MAX_VAL], either saturating or wrapping at the limits. The status
// flags and the change pulse are registered alongside the count.
module scoreboard_counter #(
    parameter int BW       = 7,
    parameter int MAX_VAL  = 99,
    parameter int CHANNELS = 2,
    parameter bit WRAP     = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CHANNELS-1:0]    up_i,
    input  logic [CHANNELS-1:0]    down_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    output logic [CHANNELS*BW-1:0] cnt_o,
    output logic [CHANNELS-1:0]    at_max_o,
    output logic [CHANNELS-1:0]    at_zero_o,
    output logic [CHANNELS-1:0]    changed_o
);

    // Refuse to elaborate with a limit that does not fit the count width
    // or with an unsupported number of channels.
    generate
        if (MAX_VAL < 0 || (MAX_VAL >> BW) != 0) begin : g_bad_max_val
            $error("scoreboard_counter: MAX_VAL must be below 2**BW");
        end
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("scoreboard_counter: CHANNELS must be in 1..8");
        end
    endgenerate

    localparam logic [BW-1:0] MAX_C  = BW'(MAX_VAL);
    localparam logic [BW-1:0] ZERO_C = {BW{1'b0}};
    localparam logic [BW-1:0] ONE_C  = {{(BW-1){1'b0}}, 1'b1};

    // Synchroniser (s1, s2) and edge-history (h) stages per direction.
    logic [CHANNELS-1:0] up_s1_d, up_s1_q, up_s2_d, up_s2_q, up_h_d, up_h_q;
    logic [CHANNELS-1:0] dn_s1_d, dn_s1_q, dn_s2_d, dn_s2_q, dn_h_d, dn_h_q;
    logic [CHANNELS-1:0] up_pulse_s, dn_pulse_s;

    logic [BW-1:0]       cnt_d [CHANNELS];
    logic [BW-1:0]       cnt_q [CHANNELS];
    logic [CHANNELS-1:0] at_max_d, at_max_q;
    logic [CHANNELS-1:0] at_zero_d, at_zero_q;
    logic [CHANNELS-1:0] changed_d, changed_q;

    // Next state of the synchroniser pipeline; it runs independently of
    // clear and enable so a held button never counts after release of those.
    always_comb begin
        up_s1_d    = up_i;
        up_s2_d    = up_s1_q;
        up_h_d     = up_s2_q;
        dn_s1_d    = down_i;
        dn_s2_d    = dn_s1_q;
        dn_h_d     = dn_s2_q;
        up_pulse_s = up_s2_q & ~up_h_q;
        dn_pulse_s = dn_s2_q & ~dn_h_q;
    end

    // Per-channel count update in priority order: clear, enable, cancel,
    // up, down. Limits are tested before the arithmetic so the stored
    // value never exceeds MAX_VAL.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clr_i) begin
                cnt_d[c] = ZERO_C;
            end else if (!en_i) begin
                cnt_d[c] = cnt_q[c];
            end else if (up_pulse_s[c] && dn_pulse_s[c]) begin
                cnt_d[c] = cnt_q[c];
            end else if (up_pulse_s[c]) begin
                if (cnt_q[c] < MAX_C) begin
                    cnt_d[c] = cnt_q[c] + ONE_C;
                end else if (WRAP) begin
                    cnt_d[c] = ZERO_C;
                end else begin
                    cnt_d[c] = cnt_q[c];
                end
            end else if (dn_pulse_s[c]) begin
                if (cnt_q[c] != ZERO_C) begin
                    cnt_d[c] = cnt_q[c] - ONE_C;
                end else if (WRAP) begin
                    cnt_d[c] = MAX_C;
                end else begin
                    cnt_d[c] = cnt_q[c];
                end
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    // Status flags are derived from the next count so they register in the
    // same edge as the count itself and always describe the stored value.
    always_comb begin
        at_max_d  = {CHANNELS{1'b0}};
        at_zero_d = {CHANNELS{1'b0}};
        changed_d = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            at_max_d[c]  = (cnt_d[c] == MAX_C);
            at_zero_d[c] = (cnt_d[c] == ZERO_C);
            changed_d[c] = (cnt_d[c] != cnt_q[c]);
        end
    end

    // State registers; reset clears everything and flags the counts as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            up_s1_q   <= {CHANNELS{1'b0}};
            up_s2_q   <= {CHANNELS{1'b0}};
            up_h_q    <= {CHANNELS{1'b0}};
            dn_s1_q   <= {CHANNELS{1'b0}};
            dn_s2_q   <= {CHANNELS{1'b0}};
            dn_h_q    <= {CHANNELS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= ZERO_C;
            end
            at_max_q  <= {CHANNELS{1'b0}};
            at_zero_q <= {CHANNELS{1'b1}};
            changed_q <= {CHANNELS{1'b0}};
        end else begin
            up_s1_q   <= up_s1_d;
            up_s2_q   <= up_s2_d;
            up_h_q    <= up_h_d;
            dn_s1_q   <= dn_s1_d;
            dn_s2_q   <= dn_s2_d;
            dn_h_q    <= dn_h_d;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            at_max_q  <= at_max_d;
            at_zero_q <= at_zero_d;
            changed_q <= changed_d;
        end
    end

    // Pack the per-channel counts onto the flat output bus.
    always_comb begin
        cnt_o = {(CHANNELS*BW){1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_o[c*BW +: BW] = cnt_q[c];
        end
    end

    assign at_max_o  = at_max_q;
    assign at_zero_o = at_zero_q;
    assign changed_o = changed_q;

endmodule

// File: doc/scoreboard_counter.md
# scoreboard_counter

Multi-channel up/down score counter with a single system clock, replacing the dual-clock counter in the scoreboard datapath. Each channel takes raw level-type up/down button lines (already debounced, asynchronous to the clock), synchronises and edge-detects them, and keeps a bounded count in [0, MAX_VAL]. Saturating or wrap-around mode, a synchronous clear, a global enable and per-channel status flags feed the display and game-logic blocks.

## Interface
- BW, 7, count width per channel; MAX_VAL must be < 2^BW, otherwise elaboration fails
- MAX_VAL, 99, upper count limit (inclusive)
- CHANNELS, 2, number of independent counters (teams); valid range is 1 to 8
- WRAP, 0, 0 means saturate at the limits; 1 means wrap MAX_VAL↔0
- clk_i  input  1  system clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- up_i  input  CHANNELS  per-channel count-up request, level, asynchronous
- down_i  input  CHANNELS  per-channel count-down request, level, asynchronous
- clr_i  input  1  synchronous clear of all counts; active-high
- en_i  input  1  global count enable; active-high
- cnt_o  output  CHANNELS*BW  counts; channel c occupies bits [c*BW +: BW]
- at_max_o  output  CHANNELS  registered; high while cnt == MAX_VAL
- at_zero_o  output  CHANNELS  registered; high while cnt == 0
- changed_o  output  CHANNELS  registered; one-cycle pulse when that channel's count changed

## Operation
- Per channel and per direction:
  - two-flop synchroniser (s1, s2), then a history flop (h)
  - the request pulse is s2 & ~h, so exactly one pulse per rising edge of the input, however long it is held
  - a falling input edge has no effect
- Per-channel update, evaluated every clock, in priority order:
  - clr_i = 1: cnt ← 0; changed pulses only if the old cnt ≠ 0
  - en_i = 0: request pulses are discarded, not queued; cnt holds
  - up and down pulses together: cnt holds (they cancel)
  - up pulse only: if cnt < MAX_VAL then cnt+1; else WRAP ? 0 : hold
  - down pulse only: if cnt > 0 then cnt−1; else WRAP ? MAX_VAL : hold
- The synchroniser and history flops run regardless of clr_i and en_i. A button held through a clear or a disabled period therefore produces no count when the block is released or re-enabled.
- Arithmetic is BW bits wide. The comparison with MAX_VAL happens before incrementing, so no value above MAX_VAL is ever stored.
- at_max_o and at_zero_o are registered together with cnt and always match the stored value.
- changed_o is set for one cycle whenever the stored count differs from its previous value, including on a wrap.
- Channels are fully independent. The same request on all channels updates all of them in the same cycle.
- Reset (rst_i low, asynchronous, takes effect immediately, including mid-operation):
  - all synchronisers, history flops and counts go to 0
  - cnt_o = 0, at_zero_o = all ones, at_max_o = 0, changed_o = 0
  - release is synchronised externally; the first clock after release performs a normal update

## Timing
- up_i or down_i rises before edge E0:
  - E0: s1 captures the input
  - E1: s2 captures it; the pulse is high until E2
  - E2: cnt, status flags and changed_o update
- Counts appear on cnt_o after the 3rd rising edge following the input transition; changed_o is high for the cycle between E2 and E3.
- Input pulses shorter than one clock period may be missed. The input must be stable for at least 2 periods high and 2 periods low to guarantee one count.
- clr_i and en_i are synchronous and take effect at the next rising edge, with zero extra latency.
- Sustained throughput is one count per input toggle, at most one per 2 clocks per channel.

## Test plan
- Reset behaviour: assert rst_i low mid-count (ch0 at 42) between clock edges → cnt_o goes to 0 immediately, at_zero_o = all ones, changed_o = 0; after release, the first up edge gives cnt=1 exactly 3 edges after the input rise.
- Saturation (WRAP=0, MAX_VAL=99): apply 105 up edges on ch0 → cnt stops at 99, at_max_o[0] = 1, changed_o stays low for the last 6 edges; 3 down edges from 0 → cnt stays 0.
- Wrap (WRAP=1): from 99, one up edge → cnt=0, changed_o pulses; one down edge → cnt=99, at_max_o = 1.
- Held input, simultaneous edges, independence:
  - hold up_i[1] high for 50 clocks → exactly one increment
  - up_i[0] and down_i[0] rising in the same cycle → cnt unchanged, no changed pulse
  - ch1 unaffected by ch0 activity throughout
- Clear and enable:
  - clr_i pulse with ch0=17 and ch1=0 → both 0 next edge; changed_o = 01
  - with en_i=0, apply 5 up edges, then set en_i=1 → cnt unchanged, no delayed counts
- Parameter sweep: BW=4, MAX_VAL=15, CHANNELS=3 → full 0→15→0 up/down sequence on each channel; compare against a reference model every cycle.
